// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - instruction memory with registered fetch port and byte-serial program loader
// Optional checksum register: define INST_MEM_CKSUM_EN.
module inst_mem #(
  parameter int ADDR  = 16,
  parameter int WORD  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR-1:0] inst_addr_i,
  input  logic            stall_i,
  output logic [WORD-1:0] inst_o,
  input  logic            ld_start_i,
  input  logic            ld_valid_i,
  input  logic [7:0]      ld_byte_i,
  input  logic            ld_last_i,
  output logic            ld_ready_o,
  output logic            ld_done_o,
  output logic            ld_ovf_o,
  output logic            busy_o,
  output logic [WORD-1:0] ld_cksum_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WORD-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [1:0]      byte_cnt;
  logic [WORD-1:0] word_buf;
  logic [WORD-1:0] wr_word;
  logic            start;
  logic            accept;
  logic            wr_en;
  logic            wr_full;
  logic            in_range;

  assign start    = (state == IDLE) && ld_start_i;
  assign accept   = (state == LOAD) && ld_valid_i;
  assign wr_en    = accept && ((byte_cnt == 2'd3) || ld_last_i);
  // Big-endian packing: byte n of a word lands at bits [WORD-1-8n -: 8]; unfilled bytes stay zero.
  assign wr_word  = word_buf | (WORD'(ld_byte_i) << (WORD - 8 - 8 * int'(byte_cnt)));
  assign wr_full  = wr_en && (wr_ptr == (AW+1)'(DEPTH - 1));
  assign in_range = 32'(inst_addr_i) < DEPTH;

  assign busy_o     = (state == LOAD);
  assign ld_ready_o = (state == LOAD);
  assign ld_done_o  = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start_i) state_nxt = LOAD;
      LOAD:    if (wr_en && (ld_last_i || wr_full)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      byte_cnt <= 2'd0;
      word_buf <= '0;
      ld_ovf_o <= 1'b0;
    end else if (start) begin
      wr_ptr   <= '0;
      byte_cnt <= 2'd0;
      word_buf <= '0;
      ld_ovf_o <= 1'b0;
    end else if (accept) begin
      if (wr_en) begin
        wr_ptr   <= wr_ptr + (AW+1)'(1);
        byte_cnt <= 2'd0;
        word_buf <= '0;
        if (wr_full && !ld_last_i) ld_ovf_o <= 1'b1;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
        word_buf <= wr_word;
      end
    end
  end

  // Storage is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_o <= '0;
    end else if (!stall_i) begin
      if (busy_o)        inst_o <= '0;
      else if (in_range) inst_o <= mem[inst_addr_i[AW-1:0]];
      else               inst_o <= '0;
    end
  end

`ifdef INST_MEM_CKSUM_EN
  logic [WORD-1:0] cksum;

  always_ff @(posedge clk) begin
    if (!rst)       cksum <= '0;
    else if (start) cksum <= '0;
    else if (wr_en) cksum <= cksum ^ wr_word;
  end

  assign ld_cksum_o = cksum;
`else
  assign ld_cksum_o = '0;
`endif

endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - scoreboard bench for inst_mem fetch port and program loader
module tb_inst_mem;

  localparam int K_INST  = 0;
  localparam int K_DONE  = 1;
  localparam int K_OVF   = 2;
  localparam int K_BUSY  = 3;
  localparam int K_READY = 4;
  localparam int K_CKSUM = 5;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        rst;
  logic [15:0] inst_addr;
  logic        stall;
  logic [31:0] inst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_ovf;
  logic        busy;
  logic [31:0] ld_cksum;

  chk_t        sb[$];
  int          cyc;
  int          checks;
  int          failures;
  bit          finish_req;
  bit          drained;
  logic [31:0] ovf_cksum;

  inst_mem dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr_i (inst_addr),
    .stall_i     (stall),
    .inst_o      (inst),
    .ld_start_i  (ld_start),
    .ld_valid_i  (ld_valid),
    .ld_byte_i   (ld_byte),
    .ld_last_i   (ld_last),
    .ld_ready_o  (ld_ready),
    .ld_done_o   (ld_done),
    .ld_ovf_o    (ld_ovf),
    .busy_o      (busy),
    .ld_cksum_o  (ld_cksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int kind);
    case (kind)
      K_INST:  return inst;
      K_DONE:  return 32'(ld_done);
      K_OVF:   return 32'(ld_ovf);
      K_BUSY:  return 32'(busy);
      K_READY: return 32'(ld_ready);
      default: return ld_cksum;
    endcase
  endfunction

  // Monitor: compares every scoreboard entry that falls due at this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = actual(sb[i].kind);
        checks = checks + 1;
        if (sb[i].due != cyc || act !== sb[i].exp) begin
          failures = failures + 1;
          $display("FAIL %s: got %h expected %h (due cycle %0d, now %0d)",
                   sb[i].name, act, sb[i].exp, sb[i].due, cyc);
        end
        sb.delete(i);
      end
    end
    if (finish_req && !drained) begin
      for (int i = 0; i < sb.size(); i++) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL %s: never compared, expected %h", sb[i].name, sb[i].exp);
      end
      sb.delete();
      drained = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input int dly, input logic [31:0] v, input string name);
    chk_t c;
    c.due  = cyc + dly;
    c.kind = kind;
    c.exp  = v;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic read(input logic [15:0] a, input logic s, input logic [31:0] v, input string name);
    inst_addr = a;
    stall     = s;
    expect_v(K_INST, 1, v, name);
    tick();
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    expect_v(K_BUSY, 0, 32'd1, "busy_in_load");
    expect_v(K_READY, 0, 32'd1, "ready_in_load");
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  function automatic logic [7:0] pat(int i);
    return 8'((i * 7 + i / 256) & 255);
  endfunction

  function automatic logic [31:0] pat_word(int k);
    return {pat(4 * k), pat(4 * k + 1), pat(4 * k + 2), pat(4 * k + 3)};
  endfunction

  function automatic logic [31:0] ck(logic [31:0] v);
`ifdef INST_MEM_CKSUM_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  initial begin
    checks = 0; failures = 0; finish_req = 1'b0; drained = 1'b0;
    rst = 1'b0; inst_addr = '0; stall = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    tick();
    tick();
    expect_v(K_INST, 0, 32'h0, "rst_inst");
    expect_v(K_BUSY, 0, 32'h0, "rst_busy");
    expect_v(K_READY, 0, 32'h0, "rst_ready");
    expect_v(K_DONE, 0, 32'h0, "rst_done");
    expect_v(K_OVF, 0, 32'h0, "rst_ovf");
    expect_v(K_CKSUM, 0, 32'h0, "rst_cksum");
    rst = 1'b1;
    tick();

    // Two-word image, last on F0.
    start_load();
    inst_addr = 16'd0;
    expect_v(K_INST, 1, 32'h0, "inst_zero_while_busy");
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    expect_v(K_CKSUM, 0, ck(32'h12345678), "cksum_after_word0");
    expect_v(K_DONE, 0, 32'h0, "no_done_mid_load");
    send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 1);
    expect_v(K_DONE, 0, 32'h1, "done_pulse");
    expect_v(K_BUSY, 0, 32'h0, "busy_in_done");
    expect_v(K_OVF, 0, 32'h0, "ovf_clear_normal");
    expect_v(K_CKSUM, 0, ck(32'h88888888), "cksum_two_words");
    expect_v(K_DONE, 1, 32'h0, "done_single_cycle");
    expect_v(K_CKSUM, 1, ck(32'h88888888), "cksum_stable");
    tick();
    read(16'd0, 0, 32'h12345678, "read_mem0");
    read(16'd1, 0, 32'h9ABCDEF0, "read_mem1");
    read(16'd1, 0, 32'h9ABCDEF0, "stall_seq_a");
    read(16'd0, 1, 32'h9ABCDEF0, "stall_seq_hold");
    read(16'd0, 0, 32'h12345678, "stall_seq_release");
    read(16'h0400, 0, 32'h0, "read_depth_nop");
    read(16'hFFFF, 0, 32'h0, "read_top_nop");
    read(16'h0401, 0, 32'h0, "read_no_wrap");

    // Short image: zero-padded partial word, persistence of mem[1].
    start_load();
    send(8'hAA, 0); send(8'hBB, 1);
    expect_v(K_DONE, 0, 32'h1, "done_partial");
    expect_v(K_CKSUM, 0, ck(32'hAABB0000), "cksum_partial");
    tick();
    read(16'd0, 0, 32'hAABB0000, "read_padded");
    read(16'd1, 0, 32'h9ABCDEF0, "read_persist");

    // Reset in the middle of the second word.
    start_load();
    inst_addr = 16'd1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h55, 0);
    expect_v(K_INST, 0, 32'h0, "inst_zero_busy_b");
    send(8'h66, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_v(K_BUSY, 0, 32'h0, "midrst_busy");
    expect_v(K_READY, 0, 32'h0, "midrst_ready");
    expect_v(K_CKSUM, 0, 32'h0, "midrst_cksum");
    expect_v(K_INST, 0, 32'h0, "midrst_inst");
    read(16'd0, 0, 32'h11223344, "midrst_mem0_kept");
    read(16'd1, 0, 32'h9ABCDEF0, "midrst_mem1_unchanged");

    // Loader bytes outside LOAD are ignored.
    ld_valid = 1'b1; ld_byte = 8'hEE;
    expect_v(K_READY, 0, 32'h0, "idle_not_ready");
    tick();
    ld_valid = 1'b0;

    // Overflow: 4*DEPTH+1 bytes, no last.
    ovf_cksum = 32'h0;
    for (int k = 0; k < 1024; k++) ovf_cksum = ovf_cksum ^ pat_word(k);
    start_load();
    for (int i = 0; i < 4096; i++) begin
      send(pat(i), 1'b0);
      if (i == 4094) expect_v(K_DONE, 0, 32'h0, "no_done_before_full");
    end
    expect_v(K_DONE, 0, 32'h1, "ovf_done");
    expect_v(K_OVF, 0, 32'h1, "ovf_flag");
    expect_v(K_READY, 0, 32'h0, "ovf_extra_not_ready");
    expect_v(K_CKSUM, 0, ck(ovf_cksum), "ovf_cksum");
    send(8'h77, 1'b0);
    expect_v(K_DONE, 0, 32'h0, "ovf_done_single");
    expect_v(K_OVF, 0, 32'h1, "ovf_sticky");
    expect_v(K_BUSY, 0, 32'h0, "ovf_idle");
    read(16'd0, 0, pat_word(0), "ovf_read_first");
    read(16'd1, 0, pat_word(1), "ovf_read_second");
    read(16'h03FF, 0, pat_word(1023), "ovf_read_last");

    // New start clears the overflow flag; single-byte image.
    start_load();
    expect_v(K_OVF, 0, 32'h0, "start_clears_ovf");
    expect_v(K_CKSUM, 0, 32'h0, "start_clears_cksum");
    send(8'h5A, 1);
    expect_v(K_DONE, 0, 32'h1, "done_one_byte");
    expect_v(K_CKSUM, 0, ck(32'h5A000000), "cksum_one_byte");
    tick();
    read(16'd0, 0, 32'h5A000000, "read_one_byte");
    read(16'd1, 0, pat_word(1), "read_one_byte_neighbour");

    tick();
    tick();
    finish_req = 1'b1;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
